// File: rtl/lutram_arbiter_pkg.sv
// Shared constants and types for the two-client LUT RAM arbiter.
package lutram_arbiter_pkg;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic REQ_0 = 1'b0;
  localparam logic REQ_1 = 1'b1;

endpackage

// File: rtl/lutram_array.sv
// DATA_W x (64x1) distributed-RAM slices: write on clk rise, combinational read, no backpressure.
module lutram_array
  import lutram_arbiter_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  for (genvar b = 0; b < DATA_W; b++) begin : g_slice
    logic [DEPTH-1:0] bits;

    always_ff @(posedge clk) begin
      if (we) bits[addr] <= wdata[b];
    end

    assign rdata[b] = bits[addr];
  end

endmodule

// File: rtl/lutram_arbiter.sv
// Round-robin arbiter sharing one 64-deep LUT RAM: one access per cycle, read data one cycle after accept.
// Losers wait on READY; optional post-reset zero sweep under LUTRAM_ARBITER_CLEAR_EN holds both READYs low.
module lutram_arbiter
  import lutram_arbiter_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              busy
);

  logic              clearing;
  logic              run;
  logic              prio;
  logic              grant;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              rd0;
  logic              rd1;

`ifdef LUTRAM_ARBITER_CLEAR_EN
  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              busy_q;

  // Counter stops at the last address; leaving ST_CLEAR ends the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      busy_q  <= 1'b1;
    end else if (state == ST_CLEAR) begin
      if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
        state  <= ST_RUN;
        busy_q <= 1'b0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  assign clearing = (state == ST_CLEAR);
  assign busy     = busy_q;
`else
  assign clearing = 1'b0;
  assign busy     = 1'b0;
`endif

  // Gating with rst_n keeps both grants low while reset is held.
  assign run        = rst_n & ~clearing;
  assign req0_ready = run & req0_valid & (~req1_valid | (prio == REQ_0));
  assign req1_ready = run & req1_valid & (~req0_valid | (prio == REQ_1));
  assign grant      = req0_ready | req1_ready;

  assign win_we    = req1_ready ? req1_we    : req0_we;
  assign win_addr  = req1_ready ? req1_addr  : req0_addr;
  assign win_wdata = req1_ready ? req1_wdata : req0_wdata;

`ifdef LUTRAM_ARBITER_CLEAR_EN
  assign ram_we    = rst_n & (clearing | (grant & win_we));
  assign ram_addr  = clearing ? clr_cnt : win_addr;
  assign ram_wdata = clearing ? '0      : win_wdata;
`else
  assign ram_we    = grant & win_we;
  assign ram_addr  = win_addr;
  assign ram_wdata = win_wdata;
`endif

  lutram_array #(
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign rd0 = req0_ready & ~req0_we;
  assign rd1 = req1_ready & ~req1_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio       <= REQ_0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= rd0;
      rsp1_valid <= rd1;
      if (rd0) rsp0_rdata <= ram_rdata;
      if (rd1) rsp1_rdata <= ram_rdata;
      if (grant) prio <= req0_ready ? REQ_1 : REQ_0;
    end
  end

endmodule
